// File: rtl/chram_sched_pkg.sv
// rtl/chram_sched_pkg.sv - shared types and defaults for the char RAM write scheduler
//
// Purpose : scheduler state encoding plus the default char RAM geometry
//           that the overlay logic also uses.
// Ports   : none (package)
package chram_sched_pkg;

    localparam int CHRAM_AW = 11;
    localparam int CHRAM_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FILL  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose : finds the first set bit of i_req, scanning upward from i_ptr
//           and wrapping modulo N.
// Ports   : i_req   N-bit request vector
//           i_ptr   scan start index
//           o_gnt   one-hot of the chosen requester (0 when none)
//           o_idx   index of the chosen requester
//           o_valid at least one request present
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin
        int j;
        j       = 0;
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[j]) begin
                o_valid  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/chram_write_sched.sv
// rtl/chram_write_sched.sv - round-robin write-port scheduler with fill engine for the char RAM
//
// Purpose : shares the char RAM write port between NREQ requesters
//           (bursts up to MAX_BURST words per grant) and a run-fill engine.
// Ports   : i_clk, reset        clock, synchronous active-high reset
//           req/req_addr/req_data/req_last  per-requester packed write stream
//           gnt                 one-hot grant; a word moves when req[i]&gnt[i]
//           fill_start/base/len/char        fill run request
//           fill_busy/fill_done fill status
//           wr_ena/wr_addr/wr_data          RAM port A write
module chram_write_sched
    import chram_sched_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int AW        = CHRAM_AW,
    parameter int DW        = CHRAM_DW,
    parameter int MAX_BURST = 16
) (
    input  logic               i_clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    gnt,
    input  logic               fill_start,
    input  logic [AW-1:0]      fill_base,
    input  logic [AW:0]        fill_len,
    input  logic [DW-1:0]      fill_char,
    output logic               fill_busy,
    output logic               fill_done,
    output logic               wr_ena,
    output logic [AW-1:0]      wr_addr,
    output logic [DW-1:0]      wr_data
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    sched_state_t    r_state, w_state_nxt;
    logic [IW-1:0]   r_ptr, w_ptr_nxt;
    logic [IW-1:0]   r_idx, w_idx_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [BW-1:0]   r_burst, w_burst_nxt;
    logic            r_wr_ena, w_wr_ena_nxt;
    logic [AW-1:0]   r_wr_addr, w_wr_addr_nxt;
    logic [DW-1:0]   r_wr_data, w_wr_data_nxt;
    logic            r_fill_done, w_fill_done_nxt;

    // Fill engine: busy covers pending + running + the done cycle,
    // pend only marks "accepted but not yet entered".
    logic            r_fill_busy;
    logic            r_fill_pend;
    logic [AW-1:0]   r_fill_addr;
    logic [AW:0]     r_fill_cnt;
    logic [DW-1:0]   r_fill_char;

    logic            w_fill_accept;
    logic            w_fill_enter;
    logic            w_fill_step;

    logic [NREQ-1:0] w_pick_gnt;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_valid;

    logic            w_sel_req;
    logic            w_sel_last;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;
    logic [BW-1:0]   w_burst_inc;
    logic [IW-1:0]   w_ptr_after;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_sel_req     = req[r_idx];
    assign w_sel_last    = req_last[r_idx];
    assign w_sel_addr    = req_addr[r_idx*AW +: AW];
    assign w_sel_data    = req_data[r_idx*DW +: DW];
    assign w_burst_inc   = r_burst + 1'b1;
    assign w_ptr_after   = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + 1'b1;
    assign w_fill_accept = fill_start && !r_fill_busy;

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_idx_nxt       = r_idx;
        w_ptr_nxt       = r_ptr;
        w_burst_nxt     = r_burst;
        w_wr_ena_nxt    = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_fill_done_nxt = 1'b0;
        w_fill_enter    = 1'b0;
        w_fill_step     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_fill_pend) begin
                    w_state_nxt  = FILL;
                    w_fill_enter = 1'b1;
                end else if (w_pick_valid) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = w_pick_gnt;
                    w_idx_nxt   = w_pick_idx;
                    w_burst_nxt = '0;
                end
            end
            GRANT: begin
                if (!w_sel_req) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_after;
                end else begin
                    w_wr_ena_nxt  = 1'b1;
                    w_wr_addr_nxt = w_sel_addr;
                    w_wr_data_nxt = w_sel_data;
                    w_burst_nxt   = w_burst_inc;
                    if (w_sel_last || (w_burst_inc == BW'(MAX_BURST))) begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_ptr_nxt   = w_ptr_after;
                    end
                end
            end
            FILL: begin
                if (r_fill_cnt != '0) begin
                    w_wr_ena_nxt  = 1'b1;
                    w_wr_addr_nxt = r_fill_addr;
                    w_wr_data_nxt = r_fill_char;
                    w_fill_step   = 1'b1;
                end
                // A zero-length run still spends one cycle here so that
                // fill_done lands the cycle after entry.
                if (r_fill_cnt <= (AW+1)'(1)) begin
                    w_fill_done_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_idx       <= '0;
            r_gnt       <= '0;
            r_burst     <= '0;
            r_wr_ena    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_fill_done <= 1'b0;
            r_fill_busy <= 1'b0;
            r_fill_pend <= 1'b0;
            r_fill_addr <= '0;
            r_fill_cnt  <= '0;
            r_fill_char <= '0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_idx       <= w_idx_nxt;
            r_gnt       <= w_gnt_nxt;
            r_burst     <= w_burst_nxt;
            r_wr_ena    <= w_wr_ena_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_fill_done <= w_fill_done_nxt;
            if (w_fill_accept) begin
                r_fill_busy <= 1'b1;
                r_fill_pend <= 1'b1;
                r_fill_addr <= fill_base;
                r_fill_cnt  <= fill_len;
                r_fill_char <= fill_char;
            end else begin
                if (w_fill_enter) begin
                    r_fill_pend <= 1'b0;
                end
                if (w_fill_step) begin
                    r_fill_addr <= r_fill_addr + 1'b1;
                    r_fill_cnt  <= r_fill_cnt - 1'b1;
                end
                if (r_fill_done) begin
                    r_fill_busy <= 1'b0;
                end
            end
        end
    end

    assign gnt       = r_gnt;
    assign wr_ena    = r_wr_ena;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign fill_busy = r_fill_busy;
    assign fill_done = r_fill_done;

endmodule

// File: tb/tb_chram_write_sched.sv
// tb/tb_chram_write_sched.sv - directed self-checking bench for chram_write_sched
module tb_chram_write_sched;

    logic        i_clk;
    logic        reset;
    logic [3:0]  req;
    logic [43:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  gnt;
    logic        fill_start;
    logic [10:0] fill_base;
    logic [11:0] fill_len;
    logic [7:0]  fill_char;
    logic        fill_busy;
    logic        fill_done;
    logic        wr_ena;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;

    chram_write_sched dut (
        .i_clk      (i_clk),
        .reset      (reset),
        .req        (req),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_last   (req_last),
        .gnt        (gnt),
        .fill_start (fill_start),
        .fill_base  (fill_base),
        .fill_len   (fill_len),
        .fill_char  (fill_char),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .wr_ena     (wr_ena),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks;
    int n_fail;

    // requester word lists
    int   ra [4][64];
    int   rd [4][64];
    bit   rl [4][64];
    int   rn [4];
    int   rp [4];
    bit   en [4];
    logic [3:0] acc;

    // observation logs
    int wa [256];
    int wd [256];
    int wc [256];
    int nw;
    int ga [16];
    int gc [16];
    int ng;
    int dc [8];
    int nd;
    int bfall;
    int tcnt;
    int tq;
    logic [3:0] prev_gnt;
    logic       prev_busy;

    int exp_g [5] = '{0, 1, 2, 3, 0};
    int exp_a [5] = '{200, 201, 202, 203, 204};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int i, input int k, input int a, input int d, input bit l);
        ra[i][k] = a;
        rd[i][k] = d;
        rl[i][k] = l;
    endtask

    task automatic apply();
        int a;
        int d;
        for (int i = 0; i < 4; i++) begin
            if (en[i] && rp[i] < rn[i]) begin
                a = ra[i][rp[i]];
                d = rd[i][rp[i]];
                req[i]            = 1'b1;
                req_addr[i*11 +: 11] = a[10:0];
                req_data[i*8 +: 8]   = d[7:0];
                req_last[i]       = rl[i][rp[i]];
            end else begin
                req[i] = 1'b0;
            end
        end
        acc = req & gnt;
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 256; i++) begin
            wa[i] = -1;
            wd[i] = -1;
            wc[i] = -1;
        end
        for (int i = 0; i < 16; i++) begin
            ga[i] = -1;
            gc[i] = -1;
        end
        for (int i = 0; i < 8; i++) dc[i] = -1;
        nw    = 0;
        ng    = 0;
        nd    = 0;
        bfall = -1;
    endtask

    task automatic tick();
        @(negedge i_clk);
        tcnt++;
        if (wr_ena && nw < 256) begin
            wa[nw] = int'(wr_addr);
            wd[nw] = int'(wr_data);
            wc[nw] = tcnt;
            nw++;
        end
        if (gnt != 4'b0 && gnt != prev_gnt && ng < 16) begin
            for (int i = 0; i < 4; i++) if (gnt[i]) ga[ng] = i;
            gc[ng] = tcnt;
            ng++;
        end
        prev_gnt = gnt;
        if (fill_done && nd < 8) begin
            dc[nd] = tcnt;
            nd++;
        end
        if (prev_busy && !fill_busy && bfall < 0) bfall = tcnt;
        prev_busy = fill_busy;
        for (int i = 0; i < 4; i++) if (acc[i]) rp[i]++;
        apply();
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b0;
            rp[i] = 0;
            rn[i] = 0;
        end
        apply();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        tcnt       = 0;
        reset      = 1'b1;
        req        = '0;
        req_addr   = '0;
        req_data   = '0;
        req_last   = '0;
        fill_start = 1'b0;
        fill_base  = '0;
        fill_len   = '0;
        fill_char  = '0;
        prev_gnt   = '0;
        prev_busy  = 1'b0;
        acc        = '0;
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b0;
            rp[i] = 0;
            rn[i] = 0;
        end
        clear_logs();
        tick();
        tick();
        check_eq("rst_gnt", int'(gnt), 0);
        check_eq("rst_wr_ena", int'(wr_ena), 0);
        check_eq("rst_wr_addr", int'(wr_addr), 0);
        check_eq("rst_wr_data", int'(wr_data), 0);
        check_eq("rst_fill_busy", int'(fill_busy), 0);
        check_eq("rst_fill_done", int'(fill_done), 0);
        reset = 1'b0;

        // single requester 1, three-word burst
        clear_logs();
        load(1, 0, 331, 'h41, 1'b0);
        load(1, 1, 340, 'h42, 1'b0);
        load(1, 2, 136, 'h43, 1'b1);
        rn[1] = 3;
        en[1] = 1'b1;
        tq = tcnt;
        apply();
        repeat (8) tick();
        check_eq("t1_gnt_idx", ga[0], 1);
        check_eq("t1_gnt_lat", gc[0] - tq, 1);
        check_eq("t1_nwrites", nw, 3);
        check_eq("t1_w0_lat", wc[0] - tq, 2);
        check_eq("t1_w2_lat", wc[2] - tq, 4);
        check_eq("t1_a0", wa[0], 331);
        check_eq("t1_a1", wa[1], 340);
        check_eq("t1_a2", wa[2], 136);
        check_eq("t1_d0", wd[0], 'h41);
        check_eq("t1_d2", wd[2], 'h43);
        check_eq("t1_gnt_end", int'(gnt), 0);
        check_eq("t1_hold_ena", int'(wr_ena), 0);
        check_eq("t1_hold_addr", int'(wr_addr), 136);
        check_eq("t1_hold_data", int'(wr_data), 'h43);

        // pointer now 2: requester 2 beats requester 0
        clear_logs();
        en[1] = 1'b0;
        load(0, 0, 10, 1, 1'b1);
        load(2, 0, 20, 2, 1'b1);
        rn[0] = 1; rp[0] = 0; en[0] = 1'b1;
        rn[2] = 1; rp[2] = 0; en[2] = 1'b1;
        apply();
        repeat (6) tick();
        check_eq("ptr_first", ga[0], 2);
        check_eq("ptr_second", ga[1], 0);
        check_eq("ptr_gap", gc[1] - gc[0], 2);
        check_eq("ptr_wa0", wa[0], 20);
        check_eq("ptr_wa1", wa[1], 10);

        // all four requesting single-word bursts
        reset_dut();
        clear_logs();
        load(0, 0, 200, 'h10, 1'b1);
        load(0, 1, 204, 'h14, 1'b1);
        load(1, 0, 201, 'h11, 1'b1);
        load(2, 0, 202, 'h12, 1'b1);
        load(3, 0, 203, 'h13, 1'b1);
        rn[0] = 2; rn[1] = 1; rn[2] = 1; rn[3] = 1;
        for (int i = 0; i < 4; i++) en[i] = 1'b1;
        tq = tcnt;
        apply();
        repeat (14) tick();
        check_eq("t2_ngrants", ng, 5);
        check_eq("t2_first_lat", gc[0] - tq, 1);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("t2_order%0d", i), ga[i], exp_g[i]);
            check_eq($sformatf("t2_addr%0d", i), wa[i], exp_a[i]);
        end
        for (int i = 1; i < 5; i++)
            check_eq($sformatf("t2_gap%0d", i), gc[i] - gc[i-1], 2);

        // MAX_BURST cut-off with a competing requester
        reset_dut();
        clear_logs();
        for (int k = 0; k < 40; k++) load(0, k, 100 + k, k, 1'b0);
        load(2, 0, 500, 'hC0, 1'b0);
        load(2, 1, 501, 'hC1, 1'b1);
        rn[0] = 40; rn[2] = 2;
        en[0] = 1'b1; en[2] = 1'b1;
        apply();
        repeat (55) tick();
        check_eq("t3_nwrites", nw, 42);
        check_eq("t3_ngrants", ng, 4);
        check_eq("t3_g0", ga[0], 0);
        check_eq("t3_g1", ga[1], 2);
        check_eq("t3_g2", ga[2], 0);
        check_eq("t3_g3", ga[3], 0);
        check_eq("t3_gap01", gc[1] - gc[0], 17);
        check_eq("t3_gap12", gc[2] - gc[1], 3);
        check_eq("t3_gap23", gc[3] - gc[2], 17);
        check_eq("t3_a15", wa[15], 115);
        check_eq("t3_a16", wa[16], 500);
        check_eq("t3_d17", wd[17], 'hC1);
        check_eq("t3_a18", wa[18], 116);
        check_eq("t3_a33", wa[33], 131);
        check_eq("t3_a34", wa[34], 132);
        check_eq("t3_a41", wa[41], 139);
        check_eq("t3_d41", wd[41], 39);
        check_eq("t3_gnt_end", int'(gnt), 0);

        // wrapping fill ahead of a waiting requester
        clear_logs();
        en[0] = 1'b0; en[2] = 1'b0;
        fill_base  = 11'd2040;
        fill_len   = 12'd16;
        fill_char  = 8'hA6;
        fill_start = 1'b1;
        tq = tcnt;
        tick();
        fill_start = 1'b0;
        load(1, 0, 77, 'h55, 1'b1);
        rn[1] = 1; rp[1] = 0; en[1] = 1'b1;
        apply();
        repeat (24) tick();
        check_eq("t4_nwrites", nw, 17);
        check_eq("t4_first_lat", wc[0] - tq, 3);
        check_eq("t4_a0", wa[0], 2040);
        check_eq("t4_a7", wa[7], 2047);
        check_eq("t4_a8", wa[8], 0);
        check_eq("t4_a15", wa[15], 7);
        check_eq("t4_last_lat", wc[15] - tq, 18);
        for (int i = 0; i < 16; i++)
            check_eq($sformatf("t4_d%0d", i), wd[i], 'hA6);
        check_eq("t4_ndone", nd, 1);
        check_eq("t4_done_with_last", dc[0], wc[15]);
        check_eq("t4_busy_fall", bfall - tq, 19);
        check_eq("t4_gnt_idx", ga[0], 1);
        check_eq("t4_gnt_lat", gc[0] - tq, 19);
        check_eq("t4_req_addr", wa[16], 77);
        check_eq("t4_req_data", wd[16], 'h55);

        // zero-length fill, second start while busy ignored
        clear_logs();
        fill_base  = 11'd5;
        fill_len   = 12'd0;
        fill_char  = 8'h11;
        fill_start = 1'b1;
        tq = tcnt;
        tick();
        fill_base = 11'd50;
        fill_len  = 12'd4;
        tick();
        fill_start = 1'b0;
        repeat (8) tick();
        check_eq("t5_nwrites", nw, 0);
        check_eq("t5_ndone", nd, 1);
        check_eq("t5_done_lat", dc[0] - tq, 3);
        check_eq("t5_busy_fall", bfall - tq, 4);
        check_eq("t5_busy_end", int'(fill_busy), 0);

        // reset in the middle of a burst
        clear_logs();
        en[1] = 1'b0;
        for (int k = 0; k < 10; k++) load(3, k, 300 + k, 'h30 + k, 1'b0);
        rn[3] = 10; rp[3] = 0; en[3] = 1'b1;
        tq = tcnt;
        apply();
        repeat (6) tick();
        check_eq("t6_pre_gnt", ga[0], 3);
        check_eq("t6_pre_nwrites", nw, 5);
        reset = 1'b1;
        tick();
        check_eq("t6_rst_gnt", int'(gnt), 0);
        check_eq("t6_rst_wr_ena", int'(wr_ena), 0);
        check_eq("t6_rst_done", int'(fill_done), 0);
        reset = 1'b0;
        clear_logs();
        for (int i = 0; i < 4; i++) rp[i] = 0;
        load(1, 0, 401, 'h61, 1'b1);
        rn[1] = 1; en[1] = 1'b1; en[3] = 1'b1;
        tq = tcnt;
        apply();
        repeat (4) tick();
        check_eq("t6_post_gnt", ga[0], 1);
        check_eq("t6_post_lat", gc[0] - tq, 1);
        check_eq("t6_post_addr", wa[0], 401);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chram_write_sched.md
# chram_write_sched

Write-port scheduler for the overlay character-index RAM. It shares the RAM's single write port between up to NREQ independent screen-update requesters, such as the tape-gear animator, progress-bar painter and status-text writer. It also contains a built-in fill engine for clearing or painting rectangles-as-runs. It sits between the overlay update logic and port A of the char RAM, and guarantees at most one write per clock with fair round-robin access.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 11, char RAM address width
- DW, 8, char code width
- MAX_BURST, 16, max words one requester may write per grant (1..256)

- i_clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  packed per-requester address, requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  packed per-requester char code
- req_last  in  NREQ  marks the final word of the requester's burst
- gnt  out  NREQ  one-hot grant; word accepted when req[i]&gnt[i]
- fill_start  in  1  pulse: start fill run
- fill_base  in  AW  first fill address
- fill_len  in  AW+1  word count (0..2^AW)
- fill_char  in  DW  fill code
- fill_busy  out  1  fill pending or running
- fill_done  out  1  one-cycle pulse at completion
- wr_ena  out  1  RAM write enable
- wr_addr  out  AW  RAM write address
- wr_data  out  DW  RAM write data

## Operation
- States: IDLE, GRANT, FILL.
- Reset: state IDLE, rr pointer 0, gnt=0, wr_ena=0, wr_addr=0, wr_data=0, fill_busy=0, fill_done=0, fill request discarded.
- fill_start is accepted only when fill_busy=0. On acceptance, base/len/char are latched and fill_busy=1 next cycle. fill_start while busy is ignored.
- IDLE priority: a pending fill wins over all requesters and moves to FILL. Otherwise the first i with req[i]=1, scanning from the rr pointer upward mod NREQ, moves to GRANT with gnt=onehot(i).
- GRANT: each cycle with req[i]=1 accepts one word (req_addr/req_data slice i) and increments the burst counter.
- GRANT terminates on any of: an accepted word with req_last=1; MAX_BURST words accepted; req[i]=0. Termination sets gnt=0 and returns to IDLE, and the rr pointer becomes (i+1) mod NREQ.
- A requester must not change its addr/data/last while req&gnt is low on the same cycle. No other restriction applies.
- FILL: writes fill_char to fill_base+k, k=0..len-1, one per cycle. The address wraps mod 2^AW. A fill is not preemptable; requesters wait.
- fill_len=0: no writes; fill_done pulses the cycle after the fill is entered.
- Fill completion pulses fill_done for one cycle, clears fill_busy, and returns to IDLE.

## Timing
- Arbitration: req seen in IDLE at cycle n gives gnt high at n+1.
- Write latency: a word accepted at cycle n appears as wr_ena=1 with its addr/data at n+1. This is the only source of wr_ena besides fill.
- Back-to-back: a granted requester sustains 1 write/cycle. There is one dead cycle (IDLE) between successive grants.
- FILL entered at cycle f: wr_ena high on f+1..f+len. fill_done pulses at f+len (with the last write); fill_busy is 0 from f+len+1.
- wr_addr/wr_data hold their last value when wr_ena=0.
- Reset mid-burst or mid-fill: no wr_ena in the cycle after reset is sampled high, and no fill_done is generated.

## Structure
- Package chram_sched_pkg: state enum (IDLE, GRANT, FILL) and default AW/DW constants shared with the overlay.
- Sub-module rr_pick: combinational round-robin picker (req vector + pointer → one-hot + index, valid). It is reused by future overlay arbiters.
- Burst counter width is $clog2(MAX_BURST+1). The fill counter is AW+1 bits.

## Test plan
- Single requester 1, three words, addr 331/340/136, last on the third → gnt[1] one cycle after req; wr_ena on 3 consecutive cycles with matching addr/data; gnt drops; pointer=2.
- req=4'b1111, each sends 1-word bursts with last=1 → grant order 0,1,2,3,0; one idle cycle between grants.
- Requester 0 holds req with last=0 for 40 words, requester 2 also requesting, MAX_BURST=16 → 16 writes from 0, then grant to 2, then 0 resumes.
- fill_start base=2040 len=16 char=0xA6 while requester 1 requests → 16 writes to 2040..2047, then 0..7; fill_done with the last write; then gnt[1].
- fill_len=0 → no wr_ena, fill_done one pulse; second fill_start during busy is ignored.
- reset asserted mid-burst after 5 words → gnt=0, wr_ena=0 the next cycle; new req arbitrates from pointer 0.
